// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch stage, the memory stage, the
// arbiter and the shared unified memory.
interface mem_arbiter_if;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifReady;

    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] dRdata;
    logic        dReady;

    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memReady;

    // The arbiter itself is the slave side of this bundle.
    modport slave (
        input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata, memReady,
        output ifRdata, ifReady, dRdata, dReady, memReq, memWe, memAddr, memWdata
    );

    modport master (
        output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata, memReady,
        input  ifRdata, ifReady, dRdata, dReady, memReq, memWe, memAddr, memWdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data accesses win over fetches, but a bounded
// run of back-to-back data grants guarantees the fetch stage makes progress.
module mem_arbiter #(
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} stateT;

    localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

    stateT      state;
    logic [3:0] run;
    logic       owner;
    logic       dataWins;

    // A pending fetch only overrides data once the data run has hit its cap.
    assign dataWins = bus.dReq && (!bus.ifReq || (run < RUN_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            run          <= 4'd0;
            owner        <= 1'b0;
            bus.memReq   <= 1'b0;
            bus.memWe    <= 1'b0;
            bus.memAddr  <= 32'd0;
            bus.memWdata <= 32'd0;
            bus.ifRdata  <= 32'd0;
            bus.dRdata   <= 32'd0;
            bus.ifReady  <= 1'b0;
            bus.dReady   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dataWins) begin
                        state        <= GNT_D;
                        owner        <= 1'b1;
                        bus.memReq   <= 1'b1;
                        bus.memWe    <= bus.dWe;
                        bus.memAddr  <= bus.dAddr;
                        bus.memWdata <= bus.dWdata;
                        if (!bus.ifReq)
                            run <= 4'd0;
                        else if (run != RUN_MAX)
                            run <= run + 4'd1;
                    end else if (bus.ifReq) begin
                        state        <= GNT_I;
                        owner        <= 1'b0;
                        bus.memReq   <= 1'b1;
                        bus.memWe    <= 1'b0;
                        bus.memAddr  <= bus.ifAddr;
                        bus.memWdata <= 32'd0;
                        run          <= 4'd0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (bus.memReady) begin
                        state      <= RESP;
                        bus.memReq <= 1'b0;
                        if (owner) begin
                            if (!bus.memWe)
                                bus.dRdata <= bus.memRdata;
                            bus.dReady <= 1'b1;
                        end else begin
                            bus.ifRdata <= bus.memRdata;
                            bus.ifReady <= 1'b1;
                        end
                    end
                end
                // Requester still holds req for the access just finished, so
                // nothing is sampled here.
                RESP: begin
                    state       <= IDLE;
                    bus.ifReady <= 1'b0;
                    bus.dReady  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a wait-state memory model answers the
// arbiter while read data is checked against queued expectations.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_D_RUN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int ifReadyCount = 0;
    int dReadyCount  = 0;
    int memTxnCount  = 0;
    int waitStates   = 0;
    int waitCnt      = 0;

    logic [31:0] expIf[$];
    logic [31:0] expD[$];

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0000_0040: return 32'h2008_0005;
            32'h0000_0200: return 32'h1234_5678;
            default:       return addr ^ 32'hCAFE_0000;
        endcase
    endfunction

    assign bus.memReady = bus.memReq && (waitCnt >= waitStates);
    assign bus.memRdata = bus.memReq ? memWord(bus.memAddr) : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst)
            waitCnt <= 0;
        else if (bus.memReq && !bus.memReady)
            waitCnt <= waitCnt + 1;
        else
            waitCnt <= 0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Ready pulses pop the scoreboard; both pulses together is always wrong.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ifReady || bus.dReady)
                checkOutput("bothReady", 32'(bus.ifReady & bus.dReady), 32'd0);
            if (bus.memReq && bus.memReady)
                memTxnCount++;
            if (bus.ifReady) begin
                ifReadyCount++;
                if (expIf.size() == 0)
                    checkOutput("ifReadyUnexpected", 32'(bus.ifReady), 32'd0);
                else
                    checkOutput("ifRdata", bus.ifRdata, expIf.pop_front());
            end
            if (bus.dReady) begin
                dReadyCount++;
                if (expD.size() == 0)
                    checkOutput("dReadyUnexpected", 32'(bus.dReady), 32'd0);
                else
                    checkOutput("dRdata", bus.dRdata, expD.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ifReqV, input logic [31:0] ifAddrV,
                                 input logic dReqV, input logic dWeV,
                                 input logic [31:0] dAddrV, input logic [31:0] dWdataV);
        bus.ifReq  = ifReqV;
        bus.ifAddr = ifAddrV;
        bus.dReq   = dReqV;
        bus.dWe    = dWeV;
        bus.dAddr  = dAddrV;
        bus.dWdata = dWdataV;
    endtask

    task automatic waitForReady(input bit forData, input int budget, output int cycles);
        cycles = 0;
        while (!(forData ? bus.dReady : bus.ifReady) && cycles < budget) begin
            tick();
            cycles++;
        end
        checkOutput(forData ? "dReadyTimeout" : "ifReadyTimeout",
                    32'(forData ? bus.dReady : bus.ifReady), 32'd1);
    endtask

    task automatic checkResetValues(input string prefix);
        checkOutput({prefix, "MemReq"},   32'(bus.memReq), 32'd0);
        checkOutput({prefix, "MemWe"},    32'(bus.memWe),  32'd0);
        checkOutput({prefix, "MemAddr"},  bus.memAddr,     32'd0);
        checkOutput({prefix, "MemWdata"}, bus.memWdata,    32'd0);
        checkOutput({prefix, "IfRdata"},  bus.ifRdata,     32'd0);
        checkOutput({prefix, "DRdata"},   bus.dRdata,      32'd0);
        checkOutput({prefix, "IfReady"},  32'(bus.ifReady), 32'd0);
        checkOutput({prefix, "DReady"},   32'(bus.dReady),  32'd0);
        checkOutput({prefix, "Run"},      32'(dut.run),     32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int g;
        int cycles;
        int dCount;
        int txn0;
        int rdy0;
        logic prevReq;
        logic [31:0] grantAddr[6];
        logic [3:0]  grantRun[6];

        grantAddr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h40, 32'h200};
        grantRun  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        // Single fetch on zero-wait memory.
        expIf.push_back(32'h2008_0005);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t1IdleMemReq", 32'(bus.memReq), 32'd0);
        tick();
        checkOutput("t1MemReq",  32'(bus.memReq), 32'd1);
        checkOutput("t1MemAddr", bus.memAddr,     32'h40);
        checkOutput("t1MemWe",   32'(bus.memWe),  32'd0);
        tick();
        checkOutput("t1IfReady", 32'(bus.ifReady), 32'd1);
        checkOutput("t1IfRdata", bus.ifRdata,      32'h2008_0005);
        checkOutput("t1RespMemReq", 32'(bus.memReq), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("t1IdleIfReady", 32'(bus.ifReady), 32'd0);
        checkOutput("t1IdleMemReq2", 32'(bus.memReq),  32'd0);

        // Store with three wait states.
        waitStates = 3;
        expD.push_back(32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t2MemReq",   32'(bus.memReq), 32'd1);
            checkOutput("t2MemWe",    32'(bus.memWe),  32'd1);
            checkOutput("t2MemAddr",  bus.memAddr,     32'h100);
            checkOutput("t2MemWdata", bus.memWdata,    32'hDEAD_BEEF);
            checkOutput("t2DReadyEarly", 32'(bus.dReady), 32'd0);
        end
        tick();
        checkOutput("t2DReady",  32'(bus.dReady),  32'd1);
        checkOutput("t2DRdata",  bus.dRdata,       32'h0);
        checkOutput("t2IfReady", 32'(bus.ifReady), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("t2DReadyPulse", 32'(bus.dReady), 32'd0);
        tick();
        checkOutput("t2DReadyCount", 32'(dReadyCount), 32'd1);
        waitStates = 0;

        // Simultaneous load and fetch: data first, fetch three cycles later.
        expD.push_back(32'h1234_5678);
        expIf.push_back(32'h2008_0005);
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h200, 32'h0);
        waitForReady(1'b1, 10, c);
        checkOutput("t3DLatency",   32'(c), 32'd2);
        checkOutput("t3DataFirst",  32'(ifReadyCount), 32'd1);
        checkOutput("t3DRdataNow",  bus.dRdata, 32'h1234_5678);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        waitForReady(1'b0, 10, c);
        checkOutput("t3IfAfterD", 32'(c), 32'd3);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        // Starvation bound: both requesters hold their requests.
        checkOutput("t4RunStart", 32'(dut.run), 32'd0);
        for (int i = 0; i < 5; i++)
            expD.push_back(32'h1234_5678);
        expIf.push_back(32'h2008_0005);
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h200, 32'h0);
        g = 0;
        cycles = 0;
        prevReq = 1'b0;
        while (g < 6 && cycles < 60) begin
            tick();
            cycles++;
            if (bus.memReq && !prevReq) begin
                checkOutput("t4GrantAddr", bus.memAddr,   grantAddr[g]);
                checkOutput("t4Run",       32'(dut.run),  32'(grantRun[g]));
                g++;
            end
            prevReq = bus.memReq;
        end
        checkOutput("t4GrantCount", 32'(g), 32'd6);
        waitForReady(1'b1, 10, c);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        // Reset while a load is stuck waiting on memory.
        waitStates = 1000;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        tick();
        checkOutput("t5InGrant", 32'(bus.memReq), 32'd1);
        rst = 1'b1;
        #1;
        checkResetValues("t5");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        rst = 1'b0;
        dCount = dReadyCount;
        repeat (5) tick();
        checkOutput("t5NoDReady", 32'(dReadyCount), 32'(dCount));
        waitStates = 0;
        expD.push_back(32'hCAFE_0300);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        waitForReady(1'b1, 10, c);
        checkOutput("t5FreshLatency", 32'(c), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Fetch held through its ready cycle must be served once.
        txn0 = memTxnCount;
        rdy0 = ifReadyCount;
        expIf.push_back(32'hCAFE_0080);
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
        waitForReady(1'b0, 10, c);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) tick();
        checkOutput("t6MemTxns",  32'(memTxnCount - txn0),  32'd1);
        checkOutput("t6IfReadys", 32'(ifReadyCount - rdy0), 32'd1);

        checkOutput("ifQueueEmpty", 32'(expIf.size()), 32'd0);
        checkOutput("dQueueEmpty",  32'(expD.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the pipeline's fetch stage and its memory stage. It accepts one fetch request and one data request, grants one at a time onto a registered memory request/ready handshake, and returns read data with a one-cycle ready pulse that the hazard logic converts into stallF/stallD. Data accesses have priority, and a bounded starvation counter guarantees fetch progress.

## Interface
- MAX_D_RUN, 4: maximum consecutive data grants issued while a fetch is pending. Range 1–15.
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word, registered
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, registered; updated only by loads
- d_ready  out  1  one-cycle pulse: data access complete
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  32  memory address, registered
- mem_wdata  out  32  memory write data, registered
- mem_rdata  in  32  memory read data; valid when mem_ready=1
- mem_ready  in  1  memory completes current access this cycle

## Operation
- States: IDLE, GNT_I, GNT_D, RESP. Reset state: IDLE.
- IDLE: samples requests.
  - d_req=1 and (if_req=0 or run<MAX_D_RUN): go to GNT_D. Latch d_we/d_addr/d_wdata into the mem_* registers.
  - Else if if_req=1: go to GNT_I. Latch if_addr; mem_we=0, mem_wdata=0.
  - Else stay in IDLE.
- GNT_I / GNT_D:
  - mem_req=1; mem_* fields held stable.
  - When mem_ready=1: go to RESP and drop mem_req.
  - GNT_I: capture mem_rdata into if_rdata.
  - GNT_D with a load: capture mem_rdata into d_rdata. GNT_D with a store: d_rdata unchanged.
  - mem_ready=0: stay. No timeout.
- RESP: owner's ready=1 for exactly this cycle. Requests are ignored here, because the requester still holds req for the completed access. Go to IDLE.
- Starvation counter run (4 bits, saturating at MAX_D_RUN):
  - A data grant with if_req=1 increments run.
  - A data grant with if_req=0 clears run.
  - Any fetch grant clears run.
- mem_req is never 1 in IDLE or RESP. mem_ready in those states is ignored.
- Owner register: 0 = fetch, 1 = data. It selects which ready pulses in RESP.
- if_ready and d_ready are never both 1.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, run=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0.
- Reset during GNT_*: mem_req drops in the same instant, the access is abandoned, and no ready pulse is issued.
- Request sampled in IDLE at edge N: mem_req=1 from cycle N+1.
- mem_ready=1 during cycle N+k (k≥1): ready pulse in cycle N+k+1; IDLE in cycle N+k+2.
- Minimum access is 3 cycles (request seen → ready → IDLE). Back-to-back throughput is one access per 3 cycles with zero-wait memory.
- Simultaneous requests in IDLE: data wins unless run==MAX_D_RUN.
- A request that rises during GNT_* or RESP waits for the next IDLE.

## Test plan
- Single fetch, zero-wait memory: if_req=1, if_addr=0x0000_0040, mem_ready=1 whenever mem_req=1, mem_rdata=0x2008_0005.
  - Expect mem_req, mem_addr=0x40, mem_we=0 in cycle 1.
  - Expect if_ready=1 and if_rdata=0x2008_0005 in cycle 2; IDLE in cycle 3.
- Store with 3 wait states: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF.
  - Expect mem_req=1, mem_we=1 and stable fields for 4 cycles.
  - Expect d_ready pulse once; d_rdata unchanged at 0; if_ready stays 0.
- Simultaneous load and fetch: d_addr=0x200, mem_rdata=0x1234_5678.
  - Expect the data grant first, with d_rdata=0x1234_5678.
  - Fetch granted in the next IDLE; if_ready 3 cycles after d_ready.
- Starvation bound, MAX_D_RUN=4: d_req and if_req both held continuously.
  - Expect exactly 4 data grants, then 1 fetch grant, then data again.
  - run observed 0,1,2,3,4,0.
- Reset mid-access: assert rst while in GNT_D with mem_ready=0.
  - Expect mem_req=0 immediately and all outputs at reset values.
  - Expect no d_ready after release; a fresh request completes normally.
- Held request not double-served: requester holds if_req through the RESP cycle and drops it the cycle after if_ready.
  - Expect exactly one memory transaction and one if_ready.
